mul_div_unit: RTL and testbench

- Multi-cycle signed multiply/divide unit beside the single-cycle ALU in the datapath.
- Takes operands from the A/B operand sources, iterates one bit per clock, and delivers a 64-bit result into the Z high/low register pair.
- The ALU handles or/and/not/add/sub combinationally; this block covers mul/div with a start/busy/done handshake so the control unit can stall.

---
 rtl/mul_div_unit.sv | 182 ++++++++++++++++++
 tb/tb_mul_div_unit.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// Multi-cycle signed multiply/divide unit.
// Multiply: radix-2 Booth, one bit per clock. Divide: restoring on magnitudes with a
// final sign fix. Result lands in the z_hi/z_lo pair together with a one-cycle done.
module mul_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             clear,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             start,
  input  logic             div_sel,
  output logic [WIDTH-1:0] z_hi,
  output logic [WIDTH-1:0] z_lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int unsigned CntW = $clog2(WIDTH);
  // Two guard bits keep Booth partial sums exact even for the most negative multiplicand.
  localparam int unsigned AccW = WIDTH + 2;

  // StInit turns the latched operands into magnitudes / Booth setup one cycle after start.
  typedef enum logic [2:0] {StIdle, StInit, StCalc, StFix, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
  logic              div_q, div_d;
  logic [AccW-1:0]   acc_q, acc_d;   // Booth accumulator or partial remainder
  logic [WIDTH-1:0]  mq_q, mq_d;     // multiplier or quotient bits
  logic              q1_q, q1_d;     // Booth q-1 bit
  logic [AccW-1:0]   opd_q, opd_d;   // multiplicand (sign-extended) or divisor magnitude
  logic [WIDTH-1:0]  z_hi_q, z_hi_d, z_lo_q, z_lo_d;
  logic              dz_q, dz_d;

  logic [WIDTH-1:0]  a_mag, b_mag;
  logic [AccW-1:0]   a_ext;
  logic [AccW-1:0]   booth_sum;
  logic [AccW-1:0]   rem_sh, trial;
  logic [WIDTH-1:0]  rem_raw, quo_fix, rem_fix;
  logic              last_step;

  // Magnitude of the most negative value is its own bit pattern read as unsigned.
  assign a_mag     = a_q[WIDTH-1] ? -a_q : a_q;
  assign b_mag     = b_q[WIDTH-1] ? -b_q : b_q;
  assign a_ext     = {{2{a_q[WIDTH-1]}}, a_q};
  assign rem_sh    = {acc_q[AccW-2:0], mq_q[WIDTH-1]};
  assign trial     = rem_sh - opd_q;
  assign rem_raw   = acc_q[WIDTH-1:0];
  assign quo_fix   = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) ? -mq_q : mq_q;
  assign rem_fix   = a_q[WIDTH-1] ? -rem_raw : rem_raw;
  assign last_step = (cnt_q == CntW'(WIDTH - 1));

  // Booth add/subtract selection from the low multiplier bit pair.
  always_comb begin
    booth_sum = acc_q;
    case ({mq_q[0], q1_q})
      2'b01:   booth_sum = acc_q + opd_q;
      2'b10:   booth_sum = acc_q - opd_q;
      default: booth_sum = acc_q;
    endcase
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    div_d   = div_q;
    acc_d   = acc_q;
    mq_d    = mq_q;
    q1_d    = q1_q;
    opd_d   = opd_q;
    z_hi_d  = z_hi_q;
    z_lo_d  = z_lo_q;
    dz_d    = dz_q;

    unique case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (start) begin
          a_d     = A;
          b_d     = B;
          div_d   = div_sel;
          dz_d    = 1'b0;
          state_d = StInit;
        end
      end
      StInit: begin
        cnt_d = '0;
        acc_d = '0;
        q1_d  = 1'b0;
        if (div_q && (b_q == '0)) begin
          z_hi_d  = a_q;
          z_lo_d  = '1;
          dz_d    = 1'b1;
          state_d = StDone;
        end else if (div_q) begin
          mq_d    = a_mag;
          opd_d   = {2'b00, b_mag};
          state_d = StCalc;
        end else begin
          mq_d    = b_q;
          opd_d   = a_ext;
          state_d = StCalc;
        end
      end
      StCalc: begin
        cnt_d = cnt_q + CntW'(1);
        if (div_q) begin
          if (!trial[AccW-1]) begin
            acc_d = trial;
            mq_d  = {mq_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_d = rem_sh;
            mq_d  = {mq_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          // Arithmetic right shift of {acc, multiplier, q-1}.
          acc_d = {booth_sum[AccW-1], booth_sum[AccW-1:1]};
          mq_d  = {booth_sum[0], mq_q[WIDTH-1:1]};
          q1_d  = mq_q[0];
        end
        if (last_step) begin
          state_d = StFix;
        end
      end
      StFix: begin
        if (div_q) begin
          z_hi_d = rem_fix;
          z_lo_d = quo_fix;
        end else begin
          z_hi_d = acc_q[WIDTH-1:0];
          z_lo_d = mq_q;
        end
        state_d = StDone;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with synchronous clear.
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      div_q   <= 1'b0;
      acc_q   <= '0;
      mq_q    <= '0;
      q1_q    <= 1'b0;
      opd_q   <= '0;
      z_hi_q  <= '0;
      z_lo_q  <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      div_q   <= div_d;
      acc_q   <= acc_d;
      mq_q    <= mq_d;
      q1_q    <= q1_d;
      opd_q   <= opd_d;
      z_hi_q  <= z_hi_d;
      z_lo_q  <= z_lo_d;
      dz_q    <= dz_d;
    end
  end

  assign busy     = (state_q == StInit) || (state_q == StCalc) || (state_q == StFix);
  assign done     = (state_q == StDone);
  assign z_hi     = z_hi_q;
  assign z_lo     = z_lo_q;
  assign div_zero = dz_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed corner cases plus random operations
// compared against a plain-arithmetic reference model.
module tb_mul_div_unit;

  logic        clock = 1'b0;
  logic        clear = 1'b1;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        start = 1'b0;
  logic        div_sel = 1'b0;
  logic [31:0] z_hi, z_lo;
  logic        busy, done, div_zero;

  int n_checks = 0;
  int n_errors = 0;

  mul_div_unit #(.WIDTH(32)) dut (
    .clock    (clock),
    .clear    (clear),
    .A        (A),
    .B        (B),
    .start    (start),
    .div_sel  (div_sel),
    .z_hi     (z_hi),
    .z_lo     (z_lo),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: signed 64-bit product; divide truncating toward zero, remainder takes
  // the dividend's sign; divide by zero returns {A, all ones} with div_zero.
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic d,
                                output logic [31:0] hi, output logic [31:0] lo,
                                output logic dz);
    longint sa, sb, p, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    dz = 1'b0;
    if (!d) begin
      p  = sa * sb;
      hi = p[63:32];
      lo = p[31:0];
    end else if (b == 32'd0) begin
      hi = a;
      lo = 32'hFFFF_FFFF;
      dz = 1'b1;
    end else begin
      q  = sa / sb;
      r  = sa % sb;
      hi = r[31:0];
      lo = q[31:0];
    end
  endfunction

  // Wait up to max edges for done; n returns edges waited (sampled #1 after each edge).
  task automatic wait_done(input int max, output int n, output logic busy_ok);
    n       = 0;
    busy_ok = 1'b1;
    do begin
      @(posedge clock);
      #1;
      n++;
      if (!done && !busy) busy_ok = 1'b0;
    end while (!done && n < max);
  endtask

  task automatic check_result(input string tag, input logic [31:0] a, input logic [31:0] b,
                              input logic d);
    logic [31:0] eh, el;
    logic        ez;
    model(a, b, d, eh, el, ez);
    check({tag, " z_hi"}, {32'd0, z_hi}, {32'd0, eh});
    check({tag, " z_lo"}, {32'd0, z_lo}, {32'd0, el});
    check({tag, " div_zero"}, {63'd0, div_zero}, {63'd0, ez});
  endtask

  // Full operation: start sampled at E0, operand inputs scrambled afterwards.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic d,
                       input string tag);
    int   lat;
    logic bok;
    @(negedge clock);
    A = a; B = b; div_sel = d; start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    A = $urandom; B = $urandom; div_sel = $urandom_range(0, 1);
    check({tag, " busy@E0"}, {63'd0, busy}, 64'd1);
    check({tag, " dz cleared"}, {63'd0, div_zero}, 64'd0);
    wait_done(80, lat, bok);
    check({tag, " latency"}, 64'(lat), (d && b == 32'd0) ? 64'd1 : 64'd34);
    check({tag, " busy window"}, {63'd0, bok}, 64'd1);
    check({tag, " busy@done"}, {63'd0, busy}, 64'd0);
    check_result(tag, a, b, d);
    @(posedge clock);
    #1;
    check({tag, " done pulse"}, {63'd0, done}, 64'd0);
  endtask

  initial begin
    int          lat;
    logic        bok;
    logic        seen;
    logic [31:0] ra, rb;
    logic        rd;

    // Reset
    repeat (3) @(posedge clock);
    #1;
    check("reset z_hi", {32'd0, z_hi}, 64'd0);
    check("reset z_lo", {32'd0, z_lo}, 64'd0);
    check("reset busy", {63'd0, busy}, 64'd0);
    check("reset done", {63'd0, done}, 64'd0);
    check("reset dz", {63'd0, div_zero}, 64'd0);
    clear = 1'b0;

    // Directed multiply and divide corners
    do_op(32'd6, 32'd7, 1'b0, "mul 6x7");
    do_op(-32'sd3, 32'd5, 1'b0, "mul -3x5");
    do_op(32'h8000_0000, 32'h8000_0000, 1'b0, "mul min*min");
    do_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, "mul max*-1");
    do_op(32'd17, 32'd5, 1'b1, "div 17/5");
    do_op(-32'sd17, 32'd5, 1'b1, "div -17/5");
    do_op(32'd17, -32'sd5, 1'b1, "div 17/-5");
    do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "div min/-1");
    do_op(32'd9, 32'd0, 1'b1, "div 9/0");
    do_op(32'd123, 32'd456, 1'b0, "mul after dz");

    // start pulsed with other operands mid-operation must be ignored
    @(negedge clock);
    A = 32'd1000; B = -32'sd77; div_sel = 1'b0; start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clock);
    #1;
    A = 32'd5; B = 32'd5; div_sel = 1'b1; start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    wait_done(80, lat, bok);
    check("ignored start latency", 64'(lat + 10), 64'd34);
    check_result("ignored start", 32'd1000, -32'sd77, 1'b0);

    // start held across DONE: second op accepted in the DONE cycle
    @(negedge clock);
    A = -32'sd100; B = 32'd7; div_sel = 1'b1; start = 1'b1;
    @(posedge clock);
    #1;
    A = 32'h1234_5678; B = 32'h0000_9ABC; div_sel = 1'b0;
    wait_done(80, lat, bok);
    check("b2b first latency", 64'(lat), 64'd34);
    check_result("b2b first", -32'sd100, 32'd7, 1'b1);
    @(posedge clock);
    #1;
    start = 1'b0;
    check("b2b accepted busy", {63'd0, busy}, 64'd1);
    wait_done(80, lat, bok);
    check("b2b second latency", 64'(lat + 1), 64'd35);
    check_result("b2b second", 32'h1234_5678, 32'h0000_9ABC, 1'b0);

    // clear mid-divide abandons the operation
    @(negedge clock);
    A = 32'd1_000_000; B = 32'd3; div_sel = 1'b1; start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (14) @(posedge clock);
    #1;
    clear = 1'b1;
    @(posedge clock);
    #1;
    clear = 1'b0;
    check("clear busy", {63'd0, busy}, 64'd0);
    check("clear done", {63'd0, done}, 64'd0);
    check("clear z", {z_hi, z_lo}, 64'd0);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clock);
      #1;
      if (done) seen = 1'b1;
    end
    check("no done after clear", {63'd0, seen}, 64'd0);
    do_op(-32'sd1_000_000, 32'd3, 1'b1, "div after clear");

    // Random operations
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = $urandom;
      rd = $urandom_range(0, 1);
      if ($urandom_range(0, 3) == 0) rb = $urandom_range(0, 20) - 10;
      if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
      do_op(ra, rb, rd, $sformatf("rand%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
